// File: rtl/thread_scheduler_pkg.sv
// Shared constants and types for the barrel thread scheduler.
package thread_sched_pkg;

  localparam int DEF_THREAD_INDEX_BITS = 3;
  localparam int DEF_NUM_THREADS       = 2 ** DEF_THREAD_INDEX_BITS;
  localparam int PC_INCREMENT          = 4;

  typedef logic [DEF_THREAD_INDEX_BITS-1:0] thread_idx_t;

  // Thread count is always a power of two so index arithmetic wraps for free.
  function automatic int num_threads(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Issue/block/writeback bus of the thread scheduler.
// THREAD_SCHED_REDIRECT_EN adds the per-thread PC redirect signals.
interface thread_scheduler_if
  import thread_sched_pkg::*;
#(
  parameter int THREAD_INDEX_BITS = 3,
  parameter int PC_WIDTH          = 32
);
  localparam int NUM_THREADS = num_threads(THREAD_INDEX_BITS);

  logic [NUM_THREADS-1:0]       in_thread_enable;
  logic                         in_stall;
  logic                         in_block_valid;
  logic [THREAD_INDEX_BITS-1:0] in_block_thread;
  logic                         in_wb_valid;
  logic [THREAD_INDEX_BITS-1:0] in_wb_thread;
`ifdef THREAD_SCHED_REDIRECT_EN
  logic                         in_redirect_valid;
  logic [THREAD_INDEX_BITS-1:0] in_redirect_thread;
  logic [PC_WIDTH-1:0]          in_redirect_pc;
`endif
  logic                         out_issue_valid;
  logic [THREAD_INDEX_BITS-1:0] out_issue_thread;
  logic [PC_WIDTH-1:0]          out_issue_pc;
  logic [NUM_THREADS-1:0]       out_blocked_mask;

  modport master (
    output in_thread_enable, in_stall, in_block_valid, in_block_thread,
           in_wb_valid, in_wb_thread,
`ifdef THREAD_SCHED_REDIRECT_EN
           in_redirect_valid, in_redirect_thread, in_redirect_pc,
`endif
    input  out_issue_valid, out_issue_thread, out_issue_pc, out_blocked_mask
  );

  modport slave (
    input  in_thread_enable, in_stall, in_block_valid, in_block_thread,
           in_wb_valid, in_wb_thread,
`ifdef THREAD_SCHED_REDIRECT_EN
           in_redirect_valid, in_redirect_thread, in_redirect_pc,
`endif
    output out_issue_valid, out_issue_thread, out_issue_pc, out_blocked_mask
  );

endinterface

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter
  import thread_sched_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic [num_threads(INDEX_BITS)-1:0] req,
  input  logic [INDEX_BITS-1:0]              ptr,
  output logic                               grant_valid,
  output logic [INDEX_BITS-1:0]              grant_index
);
  localparam int N = num_threads(INDEX_BITS);

  logic [INDEX_BITS-1:0] cand;

  // Scan offsets 1..N; offset N wraps back to ptr itself, so ptr is lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ptr + INDEX_BITS'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_index = cand;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel thread scheduler: per-cycle round-robin issue of one eligible thread
// and its PC, with per-thread blocked state set on loads, cleared on writeback.
// Optional THREAD_SCHED_REDIRECT_EN: per-thread PC redirect port.
module thread_scheduler
  import thread_sched_pkg::*;
#(
  parameter int                 THREAD_INDEX_BITS = 3,
  parameter int                 PC_WIDTH          = 32,
  parameter logic [PC_WIDTH-1:0] START_PC         = '0
) (
  input logic                clk,
  input logic                rst_n,
  thread_scheduler_if.slave  bus
);
  localparam int NUM_THREADS = num_threads(THREAD_INDEX_BITS);

  logic [NUM_THREADS-1:0]       blocked, blocked_nxt, eligible;
  logic [THREAD_INDEX_BITS-1:0] ptr, grant_index, issue_thread;
  logic                         grant_valid, issue_valid;
  logic [PC_WIDTH-1:0]          issue_pc;
  logic [PC_WIDTH-1:0]          pc [NUM_THREADS];

  assign eligible = bus.in_thread_enable & ~blocked;

  rr_arbiter #(.INDEX_BITS(THREAD_INDEX_BITS)) u_arb (
    .req         (eligible),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  // Next blocked mask: writeback clears first so a same-thread block wins.
  always_comb begin
    blocked_nxt = blocked;
    if (bus.in_wb_valid)    blocked_nxt[bus.in_wb_thread]    = 1'b0;
    if (bus.in_block_valid) blocked_nxt[bus.in_block_thread] = 1'b1;
  end

  // Issue registers, PC array, pointer and blocked mask; stall freezes issue only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_valid  <= 1'b0;
      issue_thread <= '0;
      issue_pc     <= '0;
      blocked      <= '0;
      ptr          <= '1;  // last thread, so thread 0 wins first
      for (int i = 0; i < NUM_THREADS; i++) pc[i] <= START_PC;
    end else begin
      blocked <= blocked_nxt;
      if (!bus.in_stall) begin
        issue_valid <= grant_valid;
        if (grant_valid) begin
          issue_thread       <= grant_index;
          issue_pc           <= pc[grant_index];
          pc[grant_index]    <= pc[grant_index] + PC_WIDTH'(PC_INCREMENT);
          ptr                <= grant_index;
        end
      end
`ifdef THREAD_SCHED_REDIRECT_EN
      // Placed after the increment so a redirect to the issued thread wins.
      if (bus.in_redirect_valid) pc[bus.in_redirect_thread] <= bus.in_redirect_pc;
`endif
    end
  end

  assign bus.out_issue_valid  = issue_valid;
  assign bus.out_issue_thread = issue_thread;
  assign bus.out_issue_pc     = issue_pc;
  assign bus.out_blocked_mask = blocked;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler with hand-computed expectations.
module tb_thread_scheduler;
  import thread_sched_pkg::*;

  localparam int TIB = 3;
  localparam int PCW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  thread_scheduler_if #(.THREAD_INDEX_BITS(TIB), .PC_WIDTH(PCW)) bus ();

  thread_scheduler #(.THREAD_INDEX_BITS(TIB), .PC_WIDTH(PCW), .START_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_issue(input string tag, input logic v, input int t, input int pc);
    chk({tag, ".valid"},  64'(bus.out_issue_valid),  64'(v));
    chk({tag, ".thread"}, 64'(bus.out_issue_thread), 64'(t));
    chk({tag, ".pc"},     64'(bus.out_issue_pc),     64'(pc));
  endtask

  task automatic idle_inputs();
    bus.in_thread_enable = 8'hff;
    bus.in_stall         = 1'b0;
    bus.in_block_valid   = 1'b0;
    bus.in_block_thread  = '0;
    bus.in_wb_valid      = 1'b0;
    bus.in_wb_thread     = '0;
`ifdef THREAD_SCHED_REDIRECT_EN
    bus.in_redirect_valid  = 1'b0;
    bus.in_redirect_thread = '0;
    bus.in_redirect_pc     = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int et[6];
    int ep[6];

    // Reset state, then full rotation with all threads enabled
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    exp_issue("rst", 1'b0, 0, 0);
    chk("rst.mask", 64'(bus.out_blocked_mask), 64'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_issue($sformatf("rot%0d", k), 1'b1, k, 0);
    end
    step();
    exp_issue("rot_wrap", 1'b1, 0, 4);

    // Sparse enable 0010_0101
    do_reset();
    bus.in_thread_enable = 8'b0010_0101;
    et = '{0, 2, 5, 0, 2, 5};
    ep = '{0, 0, 0, 4, 4, 4};
    for (int k = 0; k < 6; k++) begin
      step();
      exp_issue($sformatf("sparse%0d", k), 1'b1, et[k], ep[k]);
    end
    // Re-enable all: untouched threads still hold START_PC
    bus.in_thread_enable = 8'hff;
    et = '{6, 7, 0, 1, 2, 3};
    ep = '{0, 0, 8, 0, 8, 0};
    for (int k = 0; k < 6; k++) begin
      step();
      exp_issue($sformatf("reen%0d", k), 1'b1, et[k], ep[k]);
    end

    // Block thread 2, writeback five cycles later (threads 1,2 enabled)
    do_reset();
    bus.in_thread_enable = 8'b0000_0110;
    bus.in_block_valid   = 1'b1;
    bus.in_block_thread  = 3'd2;
    step();
    bus.in_block_valid = 1'b0;
    exp_issue("blk0", 1'b1, 1, 0);
    chk("blk0.mask", 64'(bus.out_blocked_mask), 64'h04);
    for (int k = 1; k < 5; k++) begin
      step();
      exp_issue($sformatf("blk%0d", k), 1'b1, 1, 4 * k);
      chk($sformatf("blk%0d.mask", k), 64'(bus.out_blocked_mask), 64'h04);
    end
    bus.in_wb_valid  = 1'b1;
    bus.in_wb_thread = 3'd2;
    step();
    bus.in_wb_valid = 1'b0;
    exp_issue("wb0", 1'b1, 1, 20);
    chk("wb0.mask", 64'(bus.out_blocked_mask), 64'h00);
    step();
    exp_issue("wb1", 1'b1, 2, 0);

    // Same-thread block+wb: block wins; different threads: both apply
    do_reset();
    bus.in_thread_enable = 8'b0000_1000;
    bus.in_block_valid   = 1'b1;
    bus.in_block_thread  = 3'd3;
    bus.in_wb_valid      = 1'b1;
    bus.in_wb_thread     = 3'd3;
    step();
    bus.in_block_valid = 1'b0;
    bus.in_wb_valid    = 1'b0;
    exp_issue("same0", 1'b1, 3, 0);
    chk("same0.mask", 64'(bus.out_blocked_mask), 64'h08);
    step();
    exp_issue("same1", 1'b0, 3, 0);
    chk("same1.mask", 64'(bus.out_blocked_mask), 64'h08);
    bus.in_block_valid  = 1'b1;
    bus.in_block_thread = 3'd5;
    bus.in_wb_valid     = 1'b1;
    bus.in_wb_thread    = 3'd3;
    step();
    bus.in_block_valid = 1'b0;
    bus.in_wb_valid    = 1'b0;
    exp_issue("diff0", 1'b0, 3, 0);
    chk("diff0.mask", 64'(bus.out_blocked_mask), 64'h20);
    step();
    exp_issue("diff1", 1'b1, 3, 4);

    // Stall for 3 cycles with a block applied during the stall
    do_reset();
    step();
    exp_issue("stl_a", 1'b1, 0, 0);
    step();
    exp_issue("stl_b", 1'b1, 1, 0);
    bus.in_stall        = 1'b1;
    bus.in_block_valid  = 1'b1;
    bus.in_block_thread = 3'd2;
    step();
    bus.in_block_valid = 1'b0;
    exp_issue("stl0", 1'b1, 1, 0);
    chk("stl0.mask", 64'(bus.out_blocked_mask), 64'h04);
    step();
    exp_issue("stl1", 1'b1, 1, 0);
    step();
    exp_issue("stl2", 1'b1, 1, 0);
    bus.in_stall = 1'b0;
    et = '{3, 4, 5, 6, 7, 0};
    ep = '{0, 0, 0, 0, 0, 4};
    for (int k = 0; k < 6; k++) begin
      step();
      exp_issue($sformatf("post%0d", k), 1'b1, et[k], ep[k]);
    end
    step();
    exp_issue("post_t1", 1'b1, 1, 4);
    step();
    exp_issue("post_skip2", 1'b1, 3, 4);

    // Block every thread as it issues, then reset with pending block/wb
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.in_block_valid  = 1'b1;
      bus.in_block_thread = 3'(k);
      step();
      exp_issue($sformatf("ab%0d", k), 1'b1, k, 0);
    end
    bus.in_block_valid = 1'b0;
    step();
    exp_issue("ab_none", 1'b0, 7, 0);
    chk("ab_none.mask", 64'(bus.out_blocked_mask), 64'hff);
    rst_n               = 1'b0;
    bus.in_block_valid  = 1'b1;
    bus.in_block_thread = 3'd4;
    bus.in_wb_valid     = 1'b1;
    bus.in_wb_thread    = 3'd4;
    step();
    exp_issue("ab_rst", 1'b0, 0, 0);
    chk("ab_rst.mask", 64'(bus.out_blocked_mask), 64'h00);
    rst_n              = 1'b1;
    bus.in_block_valid = 1'b0;
    bus.in_wb_valid    = 1'b0;
    step();
    exp_issue("ab_after0", 1'b1, 0, 0);
    step();
    exp_issue("ab_after1", 1'b1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Fine-grained (barrel) thread scheduler at the front of the multithreaded 5-stage pipeline.
- Each cycle it picks one eligible hardware thread round-robin and issues that thread's index and PC to fetch.
- The selected thread index is the one later carried through decode and used as the upper register-file address bits.
- Tracks per-thread PCs, and per-thread "blocked" state raised by loads and cleared on writeback.

Parameters:
THREAD_INDEX_BITS, 3, width of thread index; NUM_THREADS = 2**THREAD_INDEX_BITS (derived, not overridable)
PC_WIDTH, 32, width of each per-thread program counter
START_PC, 0, value loaded into every thread PC on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_thread_enable  input  NUM_THREADS  per-thread run enable; bit i = thread i may be scheduled
in_stall  input  1  downstream stall; freeze issue outputs, PCs and round-robin pointer
in_block_valid  input  1  a load was decoded; block thread in_block_thread
in_block_thread  input  THREAD_INDEX_BITS  thread to block
in_wb_valid  input  1  writeback completed; unblock thread in_wb_thread
in_wb_thread  input  THREAD_INDEX_BITS  thread to unblock
out_issue_valid  output  1  issue slot holds a valid thread this cycle
out_issue_thread  output  THREAD_INDEX_BITS  issued thread index
out_issue_pc  output  PC_WIDTH  PC of issued thread
out_blocked_mask  output  NUM_THREADS  registered per-thread blocked state

Behaviour:
- Reset (rst_n=0 at a clock edge): out_issue_valid=0, out_issue_thread=0, out_issue_pc=0, out_blocked_mask=0, all PCs=START_PC, rr pointer=NUM_THREADS-1 (thread 0 wins first).
- Eligibility (combinational): eligible[i] = in_thread_enable[i] & ~blocked[i], using the registered blocked mask.
- Selection: first eligible thread searching upward from (pointer+1), modulo NUM_THREADS.
- Issue, when not stalled, registered (1-cycle latency):
  - Some thread t is eligible: out_issue_valid=1, out_issue_thread=t, out_issue_pc=pc[t]; pc[t] <= pc[t]+4 (wraps modulo 2**PC_WIDTH); pointer <= t.
  - No thread eligible: out_issue_valid=0; thread/pc outputs hold their last values; pointer and PCs unchanged.
- in_stall=1: issue outputs, PCs and pointer hold. Block/writeback updates are still applied.
- Blocked-mask update each cycle, independent of stall:
  - set bit in_block_thread if in_block_valid;
  - clear bit in_wb_thread if in_wb_valid;
  - same thread blocked and unblocked in the same cycle: block wins (bit=1);
  - different threads: both updates apply.
- A block or writeback affects eligibility from the following cycle. A thread selected in the same cycle it is blocked is still issued.
- Deasserting in_thread_enable[i] removes thread i from eligibility immediately; its PC and blocked bit are kept.
- Reset asserted mid-operation: all state returns to reset values on that edge; pending block/writeback inputs in that cycle are ignored.

Optional Feature:
- Macro THREAD_SCHED_REDIRECT_EN.
- Defined: adds ports in_redirect_valid (1), in_redirect_thread (THREAD_INDEX_BITS), in_redirect_pc (PC_WIDTH).
  - On in_redirect_valid, pc[in_redirect_thread] <= in_redirect_pc, applied even during stall.
  - If the same thread is issued that cycle, the redirect wins over the +4 increment.
- Undefined: ports absent; PCs change only by reset and +4 increment.

Decomposition:
- Package thread_sched_pkg: NUM_THREADS derivation, PC_INCREMENT=4 constant, and a thread-index typedef.
- One sub-module, rr_arbiter: combinational NUM_THREADS-wide round-robin picker.
  - Inputs: request mask, pointer.
  - Outputs: grant_valid, grant_index.
- PC array, blocked mask and output registers live in thread_scheduler.

Test Plan:
- Reset, all 8 enabled, no blocks → from first post-reset cycle issues threads 0,1,...,7,0 with PCs 0,0,...,0 then 4 for thread 0 on its second issue.
- in_thread_enable=8'b0010_0101 → issue sequence 0,2,5,0,2,5; threads 1,3,4,6,7 never issued, their PCs stay 0.
- Block thread 2 (in_block_valid=1, in_block_thread=2); writeback thread 2 five cycles later → thread 2 skipped until the cycle after writeback; out_blocked_mask bit 2 high in between.
- Same cycle in_block_valid and in_wb_valid both for thread 3 → out_blocked_mask[3]=1 next cycle; thread 3 not issued.
- in_stall=1 for 3 cycles mid-sequence → outputs and PCs frozen; sequence resumes with the next thread after the held one; a block applied during the stall is visible afterwards.
- All threads blocked, then rst_n=0 for 1 cycle → out_issue_valid=0 while blocked; after reset the mask is clear, PCs=START_PC, and thread 0 issues first.
